// File: rtl/sr_ff_bank_if.sv
// Signal bundle for the clocked SR flip-flop bank.
// No valid/ready handshake: en, s, r and clr_err are level inputs sampled on every rising clk edge.
interface sr_ff_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] conflict;
  logic [WIDTH-1:0] locked;   // debug view of each channel FSM (1 = LOCKED)

  modport master (
    output en, s, r, clr_err,
    input  q, qb, rise, fall, conflict, locked
  );

  modport slave (
    input  en, s, r, clr_err,
    output q, qb, rise, fall, conflict, locked
  );
endinterface

// File: rtl/sr_ff_bank.sv
// WIDTH independent clocked SR cells with selectable S=R=1 resolution,
// sticky conflict flags, edge pulses and an optional per-channel dwell lockout.
module sr_ff_bank #(
  parameter int               WIDTH = 4,
  parameter int               MODE  = 0,
  parameter int               DWELL = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  sr_ff_bank_if.slave bus
);

  localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } ch_state_e;

  logic [WIDTH-1:0] q_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] conf_v;
  logic [WIDTH-1:0] locked_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic q_r;
    logic rise_r;
    logic fall_r;
    logic conf_r;
    logic dec;
    logic accept;

    always_comb begin
      dec = q_r;
      case ({bus.s[i], bus.r[i]})
        2'b10:   dec = 1'b1;
        2'b01:   dec = 1'b0;
        2'b11: begin
          case (MODE)
            1:       dec = 1'b1;
            2:       dec = 1'b0;
            3:       dec = ~q_r;
            default: dec = q_r;
          endcase
        end
        default: dec = q_r;
      endcase
    end

    if (DWELL > 0) begin : g_dwell
      ch_state_e      state;
      ch_state_e      state_nxt;
      logic [CW-1:0]  cnt;
      logic [CW-1:0]  cnt_nxt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= ST_OPEN;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // LOCKED always holds cnt >= 1 and leaves at 1, so the counter cannot underflow.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        if (bus.en) begin
          case (state)
            ST_OPEN: begin
              if (dec != q_r) begin
                accept    = 1'b1;
                state_nxt = ST_LOCKED;
                cnt_nxt   = CW'(DWELL);
              end
            end
            ST_LOCKED: begin
              cnt_nxt = cnt - 1'b1;
              if (cnt == CW'(1)) state_nxt = ST_OPEN;
            end
            default: state_nxt = ST_OPEN;
          endcase
        end
      end

      assign locked_v[i] = (state == ST_LOCKED);
    end else begin : g_nodwell
      assign accept      = bus.en && (dec != q_r);
      assign locked_v[i] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_r    <= INIT[i];
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        conf_r <= 1'b0;
      end else begin
        rise_r <= accept & dec;
        fall_r <= accept & ~dec;
        if (accept) q_r <= dec;
        // A new conflict outranks a simultaneous clear.
        if (bus.en && bus.s[i] && bus.r[i]) conf_r <= 1'b1;
        else if (bus.clr_err)               conf_r <= 1'b0;
      end
    end

    assign q_v[i]    = q_r;
    assign rise_v[i] = rise_r;
    assign fall_v[i] = fall_r;
    assign conf_v[i] = conf_r;
  end

  assign bus.q        = q_v;
  assign bus.qb       = ~q_v;
  assign bus.rise     = rise_v;
  assign bus.fall     = fall_v;
  assign bus.conflict = conf_v;
  assign bus.locked   = locked_v;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four MODE variants checked against a vector table,
// plus DWELL=3 and DWELL=4/INIT=0101 instances for lockout, freeze and reset sequences.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;
    logic [3:0] eq0, eq1, eq2, eq3;
    logic [3:0] erise, efall, econf;
  } vec_t;

  vec_t vecs[14];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_ff_bank_if #(.WIDTH(4)) bus ();
    assign bus.en      = en;
    assign bus.s       = s;
    assign bus.r       = r;
    assign bus.clr_err = clr_err;
    sr_ff_bank #(.WIDTH(4), .MODE(m), .DWELL(0), .INIT(4'b0000)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  sr_ff_bank_if #(.WIDTH(4)) if_d3 ();
  assign if_d3.en      = en;
  assign if_d3.s       = s;
  assign if_d3.r       = r;
  assign if_d3.clr_err = clr_err;
  sr_ff_bank #(.WIDTH(4), .MODE(0), .DWELL(3), .INIT(4'b0000)) u_d3 (
    .clk (clk),
    .rst (rst),
    .bus (if_d3)
  );

  sr_ff_bank_if #(.WIDTH(4)) if_d4 ();
  assign if_d4.en      = en;
  assign if_d4.s       = s;
  assign if_d4.r       = r;
  assign if_d4.clr_err = clr_err;
  sr_ff_bank #(.WIDTH(4), .MODE(0), .DWELL(4), .INIT(4'b0101)) u_d4 (
    .clk (clk),
    .rst (rst),
    .bus (if_d4)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
    en      = e;
    s       = sv;
    r       = rv;
    clr_err = c;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic [3:0] sv, input logic [3:0] rv,
                              input logic c, input logic [3:0] q0, input logic [3:0] q1,
                              input logic [3:0] q2, input logic [3:0] q3, input logic [3:0] ri,
                              input logic [3:0] fa, input logic [3:0] cf);
    vec_t v;
    v.en = e;  v.s = sv;  v.r = rv;  v.clr = c;
    v.eq0 = q0; v.eq1 = q1; v.eq2 = q2; v.eq3 = q3;
    v.erise = ri; v.efall = fa; v.econf = cf;
    return v;
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [27:0] act;
    logic [27:0] exp;

    // q per MODE 0/1/2/3, then rise/fall of MODE 3 and the shared conflict flags
    vecs[0]  = mk(1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    vecs[1]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    vecs[2]  = mk(1, 4'b0010, 4'b0001, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000);
    vecs[3]  = mk(1, 4'b0001, 4'b0001, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b0001);
    vecs[4]  = mk(1, 4'b0001, 4'b0001, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001);
    vecs[5]  = mk(1, 4'b0001, 4'b0001, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b0001);
    vecs[6]  = mk(1, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    vecs[7]  = mk(1, 4'b0001, 4'b0001, 1, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001);
    vecs[8]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001);
    vecs[9]  = mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    vecs[10] = mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    vecs[11] = mk(1, 4'b1100, 4'b0011, 0, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0000);
    vecs[12] = mk(1, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b0000);
    vecs[13] = mk(1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111);

    rst = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset takes effect before the first clock edge
    #1 rst = 1'b1;
    #1;
    chk("reset_q_mode0",   32'(g_mode[0].bus.q),  32'h0);
    chk("reset_qb_mode0",  32'(g_mode[0].bus.qb), 32'hf);
    chk("reset_q_init",    32'(if_d4.q),          32'h5);
    chk("reset_qb_init",   32'(if_d4.qb),         32'ha);
    chk("reset_rise",      32'(if_d4.rise),       32'h0);
    chk("reset_fall",      32'(if_d4.fall),       32'h0);
    chk("reset_conflict",  32'(if_d4.conflict),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: drive at negedge, expected pushed, compared at the following negedge
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].en, vecs[i].s, vecs[i].r, vecs[i].clr);
      exp_q.push_back({vecs[i].eq0, vecs[i].eq1, vecs[i].eq2, vecs[i].eq3,
                       vecs[i].erise, vecs[i].efall, vecs[i].econf});
      @(negedge clk);
      act = {g_mode[0].bus.q, g_mode[1].bus.q, g_mode[2].bus.q, g_mode[3].bus.q,
             g_mode[3].bus.rise, g_mode[3].bus.fall, g_mode[0].bus.conflict};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL vec%0d: scoreboard queue empty", i);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL vec%0d: got q0..q3/rise/fall/conf=%h expected %h", i, act, exp);
        end
      end
    end

    // DWELL=3 lockout: reset request ignored for three en-cycles, then accepted
    pulse_reset();
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    chk("dwell_set_q",      32'(if_d3.q),      32'h1);
    chk("dwell_set_rise",   32'(if_d3.rise),   32'h1);
    chk("dwell_set_locked", 32'(if_d3.locked), 32'h1);
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dwell_hold_q_%0d", k),    32'(if_d3.q),    32'h1);
      chk($sformatf("dwell_hold_fall_%0d", k), 32'(if_d3.fall), 32'h0);
    end
    @(negedge clk);
    chk("dwell_clear_q",    32'(if_d3.q),    32'h0);
    chk("dwell_clear_fall", 32'(if_d3.fall), 32'h1);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    chk("dwell_fall_once",  32'(if_d3.fall), 32'h0);

    // en=0 freezes q, conflict and the dwell counter mid-lockout
    pulse_reset();
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    chk("freeze_pre_q", 32'(if_d3.q), 32'h1);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("freeze_q_%0d", k),      32'(if_d3.q),        32'h1);
      chk($sformatf("freeze_rise_%0d", k),   32'(if_d3.rise),     32'h0);
      chk($sformatf("freeze_locked_%0d", k), 32'(if_d3.locked),   32'h1);
      chk($sformatf("freeze_conf_%0d", k),   32'(if_d3.conflict), 32'h0);
    end
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    chk("resume_q_a", 32'(if_d3.q), 32'h1);
    @(negedge clk);
    chk("resume_q_b",      32'(if_d3.q),      32'h1);
    chk("resume_unlocked", 32'(if_d3.locked), 32'h0);
    @(negedge clk);
    chk("resume_clear_q",    32'(if_d3.q),    32'h0);
    chk("resume_clear_fall", 32'(if_d3.fall), 32'h1);

    // DWELL=4: reset while ch1 is LOCKED returns to INIT at once
    pulse_reset();
    drive(1'b1, 4'b1010, 4'b1000, 1'b0);
    @(negedge clk);
    chk("lock_q",        32'(if_d4.q),        32'h7);
    chk("lock_rise",     32'(if_d4.rise),     32'h2);
    chk("lock_conflict", 32'(if_d4.conflict), 32'h8);
    chk("lock_locked",   32'(if_d4.locked),   32'h2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q",        32'(if_d4.q),        32'h5);
    chk("midrst_qb",       32'(if_d4.qb),       32'ha);
    chk("midrst_rise",     32'(if_d4.rise),     32'h0);
    chk("midrst_fall",     32'(if_d4.fall),     32'h0);
    chk("midrst_conflict", 32'(if_d4.conflict), 32'h0);
    chk("midrst_locked",   32'(if_d4.locked),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'b0010, 4'b0001, 1'b0);
    @(negedge clk);
    chk("postrst_q",    32'(if_d4.q),    32'h6);
    chk("postrst_rise", 32'(if_d4.rise), 32'h2);
    chk("postrst_fall", 32'(if_d4.fall), 32'h1);
    drive(1'b1, 4'b0000, 4'b0010, 1'b0);
    @(negedge clk);
    chk("postrst_relock_q", 32'(if_d4.q), 32'h6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
